// File: rtl/logic_shift_unit.sv
// -----------------------------------------------------------------------------
// logic_shift_unit
//   Handshaked logic/shift unit between operand-fetch and writeback.
//   Bitwise ops and single-bit shifts complete one cycle after accept.
//   Variable shifts/rotates (ops 9-13) run serially, one bit per cycle,
//   taking k+1 cycles from accept to result. Results are held until the
//   downstream stage takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand/opcode valid
//   in_ready   unit can accept an operation
//   in_a       operand A
//   in_b       operand B; low SHW bits are the shift amount for ops 9-13
//   select     opcode (0 AND, 1 OR, 2 XOR, 3 ~A, 4 ~B, 5 A, 6 B, 7 A<<1,
//              8 A>>1, 9 SHL k, 10 SHR k, 11 SRA k, 12 ROL k, 13 ROR k,
//              14-15 illegal)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   logic_out  result
//   err        illegal opcode flag, qualified by out_valid
//   busy       serial shift in progress
// -----------------------------------------------------------------------------
module logic_shift_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] logic_out,
    output logic             err,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             err_q, err_d;

    logic             accept;
    logic             is_shift_op;
    logic [SHW-1:0]   k_in;
    logic [WIDTH-1:0] work_step;

    // Single-cycle result. Ops 9-13 only reach here with a zero shift
    // amount, in which case the result is operand A unchanged.
    function automatic logic [WIDTH-1:0] single_result(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a ^ b;
            4'd3:    r = ~a;
            4'd4:    r = ~b;
            4'd5:    r = a;
            4'd6:    r = b;
            4'd7:    r = {a[WIDTH-2:0], 1'b0};
            4'd8:    r = {1'b0, a[WIDTH-1:1]};
            4'd9, 4'd10, 4'd11, 4'd12, 4'd13:
                     r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One bit of a serial shift/rotate.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] w
    );
        logic [WIDTH-1:0] r;
        case (op)
            4'd9:    r = {w[WIDTH-2:0], 1'b0};
            4'd10:   r = {1'b0, w[WIDTH-1:1]};
            4'd11:   r = {w[WIDTH-1], w[WIDTH-1:1]};
            4'd12:   r = {w[WIDTH-2:0], w[WIDTH-1]};
            4'd13:   r = {w[0], w[WIDTH-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign in_ready    = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept      = in_valid && in_ready;
    assign is_shift_op = (select >= 4'd9) && (select <= 4'd13);
    assign k_in        = in_b[SHW-1:0];
    assign work_step   = shift_step(op_q, work_q);

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == SHIFT);
    assign logic_out = res_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;

        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (is_shift_op && (k_in != '0)) begin
                        work_d  = in_a;
                        cnt_d   = k_in;
                        op_d    = select;
                        state_d = SHIFT;
                    end else begin
                        // From HOLD this consumes the old result and loads
                        // the new one on the same edge: no bubble.
                        res_d   = single_result(select, in_a, in_b);
                        err_d   = (select >= 4'd14);
                        state_d = HOLD;
                    end
                end else if (state_q == HOLD && out_ready) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    res_d   = work_step;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_logic_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_logic_shift_unit
//   Self-checking bench for logic_shift_unit (WIDTH=16). Expected results come
//   from a reference model using plain shift/rotate arithmetic; expected
//   latency is 1 cycle, or k+1 cycles for variable shifts with k>0.
// -----------------------------------------------------------------------------
module tb_logic_shift_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  select;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] logic_out;
    logic        err;
    logic        busy;

    int n_checks;
    int n_fail;

    logic_shift_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .logic_out (logic_out),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    // Reference model: {err, result}
    function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] sel);
        int               k;
        logic signed [15:0] sa;
        logic [15:0]      r;
        logic             e;
        k  = int'(b[3:0]);
        sa = a;
        e  = 1'b0;
        case (sel)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a ^ b;
            4'd3:  r = ~a;
            4'd4:  r = ~b;
            4'd5:  r = a;
            4'd6:  r = b;
            4'd7:  r = a << 1;
            4'd8:  r = a >> 1;
            4'd9:  r = a << k;
            4'd10: r = a >> k;
            4'd11: r = sa >>> k;
            4'd12: r = (a << k) | (a >> (16 - k));
            4'd13: r = (a >> k) | (a << (16 - k));
            default: begin r = 16'h0000; e = 1'b1; end
        endcase
        return {e, r};
    endfunction

    function automatic int ref_latency(input logic [15:0] b, input logic [3:0] sel);
        if (sel >= 4'd9 && sel <= 4'd13 && b[3:0] != 4'd0) return int'(b[3:0]) + 1;
        return 1;
    endfunction

    // Issue one op from IDLE with out_ready=1 and wait (bounded) for its result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                          output logic [15:0] res, output logic e, output int lat,
                          output int busy_n, output int rdy_in_busy);
        @(negedge clk);
        in_a = a; in_b = b; select = sel; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; busy_n = 0; rdy_in_busy = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_n++;
            if (busy && in_ready) rdy_in_busy++;
            @(negedge clk);
            lat++;
        end
        res = logic_out;
        e   = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; select = '0;
        #12;
        n_checks++;
        if ({out_valid, logic_out, err, busy, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b out=%h err=%b busy=%b rdy=%b, need 0 0000 0 0 1",
                     out_valid, logic_out, err, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_logic_ops();
        logic [15:0] exp_tab [0:8];
        logic [15:0] res, a, b;
        logic [16:0] m;
        logic        e;
        logic [3:0]  sel;
        int          lat, bn, rb;
        exp_tab = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0F0F, 16'hF00F,
                    16'hF0F0, 16'h0FF0, 16'hE1E0, 16'h7878};
        for (int i = 0; i < 9; i++) begin
            run_op(16'hF0F0, 16'h0FF0, 4'(i), res, e, lat, bn, rb);
            n_checks++;
            if (res !== exp_tab[i] || e !== 1'b0 || lat != 1) begin
                n_fail++;
                $display("FAIL logic_op%0d: got out=%h err=%b lat=%0d, need %h 0 1",
                         i, res, e, lat, exp_tab[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom); b = 16'($urandom); sel = 4'($urandom_range(0, 8));
            m = ref_model(a, b, sel);
            run_op(a, b, sel, res, e, lat, bn, rb);
            n_checks++;
            if (res !== m[15:0] || e !== m[16] || lat != 1) begin
                n_fail++;
                $display("FAIL rand_logic sel=%0d a=%h b=%h: got %h err=%b lat=%0d, need %h err=%b lat=1",
                         sel, a, b, res, e, lat, m[15:0], m[16]);
            end
        end
    endtask

    task automatic test_shifts();
        logic [15:0] res, a, b;
        logic [16:0] m;
        logic        e;
        logic [3:0]  sel;
        int          lat, bn, rb, el;
        logic [3:0]  d_sel [0:5];
        logic [15:0] d_a   [0:5];
        logic [15:0] d_b   [0:5];
        logic [15:0] d_exp [0:5];
        d_sel = '{4'd11, 4'd10, 4'd13, 4'd12, 4'd9, 4'd12};
        d_a   = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h1234, 16'h0001};
        d_b   = '{16'h0004, 16'h0004, 16'h0004, 16'h0001, 16'h0010, 16'h000F};
        d_exp = '{16'hF800, 16'h0800, 16'h1800, 16'h0003, 16'h1234, 16'h8000};
        for (int i = 0; i < 6; i++) begin
            el = ref_latency(d_b[i], d_sel[i]);
            run_op(d_a[i], d_b[i], d_sel[i], res, e, lat, bn, rb);
            n_checks++;
            if (res !== d_exp[i] || e !== 1'b0 || lat != el || bn != el - 1 || rb != 0) begin
                n_fail++;
                $display("FAIL shift_dir%0d sel=%0d: got %h err=%b lat=%0d busy=%0d rdy_busy=%0d, need %h 0 lat=%0d busy=%0d 0",
                         i, d_sel[i], res, e, lat, bn, rb, d_exp[i], el, el - 1);
            end
        end
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom); b = 16'($urandom); sel = 4'($urandom_range(9, 13));
            m  = ref_model(a, b, sel);
            el = ref_latency(b, sel);
            run_op(a, b, sel, res, e, lat, bn, rb);
            n_checks++;
            if (res !== m[15:0] || e !== 1'b0 || lat != el || bn != el - 1 || rb != 0) begin
                n_fail++;
                $display("FAIL rand_shift sel=%0d a=%h k=%0d: got %h lat=%0d busy=%0d rdy_busy=%0d, need %h lat=%0d busy=%0d",
                         sel, a, b[3:0], res, lat, bn, rb, m[15:0], el, el - 1);
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] res;
        logic        e;
        int          lat, bn, rb;
        for (int s = 14; s < 16; s++) begin
            run_op(16'hABCD, 16'h1234, 4'(s), res, e, lat, bn, rb);
            n_checks++;
            if (res !== 16'h0000 || e !== 1'b1 || lat != 1) begin
                n_fail++;
                $display("FAIL illegal%0d: got %h err=%b lat=%0d, need 0000 err=1 lat=1", s, res, e, lat);
            end
        end
        run_op(16'hF0F0, 16'h0FF0, 4'd0, res, e, lat, bn, rb);
        n_checks++;
        if (res !== 16'h00F0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clear: got %h err=%b, need 00F0 err=0", res, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, exp_r;
        logic [3:0]  sel;
        logic [16:0] m;
        @(negedge clk);
        in_a = 16'hF0F0; in_b = 16'h0FF0; select = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || logic_out !== 16'hFF00 || err !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure cyc%0d: got ov=%b out=%h err=%b rdy=%b, need 1 FF00 0 0",
                         i, out_valid, logic_out, err, in_ready);
            end
            @(negedge clk);
        end
        a = 16'($urandom); b = 16'($urandom);
        in_a = a; in_b = b; select = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ready: got in_ready=%b, need 1", in_ready);
        end
        exp_r = a | b;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || logic_out !== exp_r || err !== 1'b0) begin
                n_fail++;
                $display("FAIL back_to_back%0d: got ov=%b out=%h err=%b, need 1 %h 0",
                         i, out_valid, logic_out, err, exp_r);
            end
            a = 16'($urandom); b = 16'($urandom); sel = 4'($urandom_range(0, 8));
            m = ref_model(a, b, sel);
            in_a = a; in_b = b; select = sel; exp_r = m[15:0];
            @(posedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || logic_out !== exp_r) begin
            n_fail++;
            $display("FAIL back_to_back_last: got ov=%b out=%h, need 1 %h", out_valid, logic_out, exp_r);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_idle: got ov=%b rdy=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] res;
        logic        e;
        int          lat, bn, rb;
        @(negedge clk);
        in_a = 16'h1357; in_b = 16'h000A; select = 4'd12; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_shift: got busy=%b rdy=%b ov=%b, need 1 0 0", busy, in_ready, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, logic_out, err, busy, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got ov=%b out=%h err=%b busy=%b rdy=%b, need 0 0000 0 0 1",
                     out_valid, logic_out, err, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got rdy=%b busy=%b, need 1 0", in_ready, busy);
        end
        run_op(16'hF0F0, 16'h0FF0, 4'd0, res, e, lat, bn, rb);
        n_checks++;
        if (res !== 16'h00F0 || e !== 1'b0 || lat != 1) begin
            n_fail++;
            $display("FAIL post_reset_and: got %h err=%b lat=%0d, need 00F0 0 1", res, e, lat);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_logic_ops();
        test_shifts();
        test_illegal();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_shift_unit.md
Name: logic_shift_unit

Overview:
- Parametrised, handshaked successor to the 16-bit combinational logic unit.
- Adds registered output, valid/ready flow control, and variable-amount shift and rotate ops.
- Variable shifts run serially, one bit per cycle, to save area.
- Sits between operand-fetch and writeback in the datapath. Opcodes 0–8 keep the existing encoding.

Parameters:
WIDTH, 16, operand and result width in bits (>= 2)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk        input   1        rising-edge clock
rst        input   1        asynchronous active-high reset
in_valid   input   1        operand/opcode valid
in_ready   output  1        unit can accept an operation
in_a       input   WIDTH    operand A
in_b       input   WIDTH    operand B; bits [SHW-1:0] are the shift amount for ops 9–13
select     input   4        opcode
out_valid  output  1        result valid
out_ready  input   1        downstream accepts result
logic_out  output  WIDTH    result
err        output  1        opcode was illegal (14–15); qualified by out_valid
busy       output  1        serial shift in progress

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 ~A, 4 ~B, 5 pass A, 6 pass B
  - 7 A<<1, 8 A>>1 (logical)
  - 9 SHL by k, 10 SHR-logical by k, 11 SHR-arithmetic by k, 12 ROL by k, 13 ROR by k, with k = in_b[SHW-1:0]
  - 14–15 illegal: result 0, err=1
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; logic_out=0; err=0; busy=0. Any in-flight op is discarded.
- Accept occurs on a rising edge with in_valid && in_ready. in_a, in_b and select are sampled only at accept.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE, accept, op 0–8 or 14–15, or ops 9–13 with k=0: result registered at the accept edge; go to HOLD. out_valid is high the cycle after accept (latency 1).
  - IDLE, accept, ops 9–13 with k>0: work register := in_a, counter := k; go to SHIFT; busy=1.
  - SHIFT: each edge shifts/rotates the work register by one bit and decrements the counter.
    - SHL fills 0. SHR fills 0. SRA fills the MSB. ROL/ROR wrap the bit around.
    - On the edge where the counter goes 1→0, go to HOLD with the result. Total latency is k+1 cycles after accept.
    - k = WIDTH-1 is the maximum amount; no wrap of k.
  - HOLD: out_valid=1. logic_out and err are stable while !out_ready.
    - out_ready=1 with no new accept: go to IDLE.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). In SHIFT, in_ready=0.
- Back-to-back: in HOLD with out_ready=1 and in_valid=1, the result is consumed and the new op is accepted on the same edge. A single-cycle op stays in HOLD with the new result, so there are no bubbles.
- busy=1 exactly in SHIFT. out_valid=0 in IDLE and SHIFT.
- Upper bits of in_b above SHW are ignored for ops 9–13. Ops 7–8 ignore in_b.
- Results are exactly WIDTH bits; shifted-out bits are discarded.

Test Plan:
- WIDTH=16. AND A=0xF0F0, B=0x0FF0 with out_ready=1 → out_valid 1 cycle after accept, logic_out=0x00F0, err=0; ops 1–8 on the same operands → 0xFFF0, 0xFF00, 0x0F0F, 0xF00F, 0xF0F0, 0x0FF0, 0xE1E0, 0x7878.
- SRA A=0x8001, B=0x0004 → busy high for 4 cycles, in_ready=0 throughout, logic_out=0xF800 at latency 5. SHR on the same operands → 0x0800. ROR → 0x1800. ROL by 1 → 0x0003.
- Shift k=0 (op 9, B=0x0010 so low 4 bits are 0) → logic_out=A after 1 cycle, busy never asserts. k=15 ROL of 0x0001 → 0x8000 after 16 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after the XOR result → logic_out/err stable, in_ready=0. Then raise out_ready with a new in_valid OR → consumed and accepted on the same edge; the next result appears the following cycle.
- Illegal select=14 and select=15 → logic_out=0x0000, err=1, out_valid=1. Next legal op clears err.
- Assert rst mid-SHIFT (op 12, k=10, after 3 cycles) → outputs zero immediately, before the next edge; in_ready=1 after release; a fresh AND op completes correctly.
